pc_unit: RTL

- Registered program-counter unit for the dCPU fetch stage; successor to the combinational next-PC selector.
- Holds the current PC and evaluates the branch/jump opcode, including signed and unsigned compares.
- Adds a call/return stack (return-address stack, RAS) for jal/ret.
- Supports a pipeline stall, and is parametrised in data width, opcode width, PC increment, reset vector and RAS depth.

---
 rtl/pc_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Fetch-stage program counter: holds pc, resolves branch/jump targets and
// keeps a circular return-address stack for jal/ret.
module pc_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      OP_W      = 6,
  parameter int unsigned      PC_INC    = 4,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  input  logic [WIDTH-1:0] branch,
  input  logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] npc,
  output logic             taken,
  output logic [WIDTH-1:0] link,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(32);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(33);
  localparam logic [OP_W-1:0] OP_BLTU = OP_W'(34);
  localparam logic [OP_W-1:0] OP_BLEU = OP_W'(35);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(36);
  localparam logic [OP_W-1:0] OP_BLE  = OP_W'(37);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(40);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(41);
  localparam logic [OP_W-1:0] OP_JR   = OP_W'(42);
  localparam logic [OP_W-1:0] OP_RET  = OP_W'(43);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] seq;
  logic [PTR_W-1:0] top_inc;
  logic             eq;
  logic             lt_u;
  logic             lt_s;
  logic             push_c;
  logic             pop_c;
  logic             under_c;

  assign seq       = pc + WIDTH'(PC_INC);
  assign link      = seq;
  assign top_inc   = top + PTR_W'(1);
  assign eq        = (reg1 == reg2);
  assign lt_u      = (reg1 < reg2);
  assign lt_s      = ($signed(reg1) < $signed(reg2));
  assign ras_empty = (count == '0);
  assign ras_full  = (count == CNT_W'(RAS_DEPTH));

  // Next-pc select; unknown or unused opcodes fall through to seq.
  always_comb begin
    npc     = seq;
    taken   = 1'b0;
    push_c  = 1'b0;
    pop_c   = 1'b0;
    under_c = 1'b0;
    case (op)
      OP_BEQ:  taken = eq;
      OP_BNE:  taken = !eq;
      OP_BLTU: taken = lt_u;
      OP_BLEU: taken = lt_u || eq;
      OP_BLT:  taken = lt_s;
      OP_BLE:  taken = lt_s || eq;
      OP_J: begin
        npc   = addr;
        taken = 1'b1;
      end
      OP_JAL: begin
        npc    = addr;
        taken  = 1'b1;
        push_c = 1'b1;
      end
      OP_JR: begin
        npc   = reg1;
        taken = 1'b1;
      end
      OP_RET: begin
        if (ras_empty) begin
          under_c = 1'b1;
        end else begin
          npc   = ras_mem[top];
          taken = 1'b1;
          pop_c = 1'b1;
        end
      end
      default: ;
    endcase
    if (taken && (op >= OP_BEQ) && (op <= OP_BLE)) npc = branch;
  end

  // pc, stack pointer/count and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      top     <= '0;
      count   <= '0;
      ras_err <= 1'b0;
    end else if (en) begin
      pc      <= npc;
      ras_err <= (push_c && ras_full) || under_c;
      if (push_c) begin
        top <= top_inc;
        if (!ras_full) count <= count + CNT_W'(1);
      end else if (pop_c) begin
        top   <= top - PTR_W'(1);
        count <= count - CNT_W'(1);
      end
    end else begin
      ras_err <= 1'b0;
    end
  end

  // Stack storage needs no reset; a full push overwrites the oldest slot.
  always_ff @(posedge clk) begin
    if (!rst && en && push_c) ras_mem[top_inc] <= seq;
  end

endmodule
